except_ctrl: RTL and testbench

- Exception/interrupt sequencer between the MEM stage and the CP0 register file.
- Accepts the MEM-stage exception flags and CP0 Status/Cause/EPC, with WB-stage CP0 write bypass.
- Resolves priority and emits a one-cycle exception type code to CP0.
- Drives the pipeline flush and redirect PC through a small FSM that blocks re-entry while the pipeline drains.

---
 rtl/except_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_except_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/except_ctrl.sv
// Exception/interrupt sequencer: MEM-stage flags plus CP0 state (with WB bypass) in, one-shot code, flush and redirect out.
// Optional EXCEPT_STATS_EN adds saturating interrupt/exception event counters.
module except_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
   parameter int          FLUSH_CYCLES = 1,
   parameter int          DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic        mem_stall_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_in_delayslot_i,
   input  logic        exc_syscall_i,
   input  logic        exc_inst_invalid_i,
   input  logic        exc_trap_i,
   input  logic        exc_ovf_i,
   input  logic        exc_eret_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_wdata_i,
`ifdef EXCEPT_STATS_EN
   output logic [15:0] stat_int_cnt_o,
   output logic [15:0] stat_exc_cnt_o,
`endif
   output logic [31:0] excepttype_o,
   output logic [31:0] except_pc_o,
   output logic        except_dslot_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

   localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
   localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

   localparam logic [31:0] CODE_INT     = 32'h01;
   localparam logic [31:0] CODE_ERET    = 32'h0e;
   localparam logic [31:0] CODE_SYSCALL = 32'h08;
   localparam logic [31:0] CODE_INVALID = 32'h0a;
   localparam logic [31:0] CODE_TRAP    = 32'h0d;
   localparam logic [31:0] CODE_OVF     = 32'h0c;

   state_t      state_reg, state_next;
   logic [2:0]  cnt_reg, cnt_next;
   logic [31:0] type_reg, type_next;
   logic [31:0] epc_out_reg, epc_out_next;
   logic        dslot_reg, dslot_next;
   logic [31:0] new_pc_reg, new_pc_next;

   logic [31:0] status_eff, cause_eff, epc_eff;
   logic        int_pending, accept;
   logic [31:0] code;
   logic        unused_bits;

   // WB writes to CP0 are not visible in the register file yet, so forward them here.
   always_comb begin
      status_eff = cp0_status_i;
      cause_eff  = cp0_cause_i;
      epc_eff    = cp0_epc_i;
      if (wb_cp0_we_i) begin
         case (wb_cp0_waddr_i)
            5'd12: status_eff = wb_cp0_wdata_i;
            5'd13: begin
               cause_eff[9:8] = wb_cp0_wdata_i[9:8];
               cause_eff[22]  = wb_cp0_wdata_i[22];
               cause_eff[23]  = wb_cp0_wdata_i[23];
            end
            5'd14: epc_eff = wb_cp0_wdata_i;
            default: ;
         endcase
      end
   end

   assign unused_bits = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:16], cause_eff[7:0]};

   assign int_pending = (|(cause_eff[15:8] & status_eff[15:8])) && status_eff[0] && !status_eff[1];
   assign accept      = mem_valid_i && !mem_stall_i;

   always_comb begin
      code = 32'h0;
      if (int_pending)             code = CODE_INT;
      else if (exc_eret_i)         code = CODE_ERET;
      else if (exc_syscall_i)      code = CODE_SYSCALL;
      else if (exc_inst_invalid_i) code = CODE_INVALID;
      else if (exc_trap_i)         code = CODE_TRAP;
      else if (exc_ovf_i)          code = CODE_OVF;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= 3'd0;
         type_reg    <= 32'h0;
         epc_out_reg <= 32'h0;
         dslot_reg   <= 1'b0;
         new_pc_reg  <= 32'h0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         type_reg    <= type_next;
         epc_out_reg <= epc_out_next;
         dslot_reg   <= dslot_next;
         new_pc_reg  <= new_pc_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      type_next    = 32'h0;
      epc_out_next = epc_out_reg;
      dslot_next   = dslot_reg;
      new_pc_next  = new_pc_reg;
      case (state_reg)
         IDLE: begin
            if (accept && code != 32'h0) begin
               state_next   = FLUSH;
               cnt_next     = 3'd0;
               type_next    = code;
               epc_out_next = mem_pc_i;
               dslot_next   = mem_in_delayslot_i;
               new_pc_next  = (code == CODE_ERET) ? epc_eff : EXC_VECTOR;
            end
         end
         FLUSH: begin
            if (cnt_reg == FLUSH_LAST) begin
               cnt_next    = 3'd0;
               new_pc_next = 32'h0;
               state_next  = (DRAIN_CYCLES == 0) ? IDLE : DRAIN;
            end else begin
               cnt_next = (cnt_reg == 3'd7) ? 3'd7 : cnt_reg + 3'd1;
            end
         end
         DRAIN: begin
            if (cnt_reg == DRAIN_LAST) begin
               cnt_next   = 3'd0;
               state_next = IDLE;
            end else begin
               cnt_next = (cnt_reg == 3'd7) ? 3'd7 : cnt_reg + 3'd1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 3'd0;
         end
      endcase
   end

   assign excepttype_o   = type_reg;
   assign except_pc_o    = epc_out_reg;
   assign except_dslot_o = dslot_reg;
   assign new_pc_o       = new_pc_reg;
   assign flush_o        = (state_reg == FLUSH);
   assign busy_o         = (state_reg != IDLE);

`ifdef EXCEPT_STATS_EN
   logic [15:0] int_cnt_reg, exc_cnt_reg;
   logic        take;

   assign take = (state_reg == IDLE) && accept && (code != 32'h0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int_cnt_reg <= 16'h0;
         exc_cnt_reg <= 16'h0;
      end else if (take) begin
         if (code == CODE_INT) begin
            if (int_cnt_reg != 16'hffff) int_cnt_reg <= int_cnt_reg + 16'd1;
         end else if (code != CODE_ERET) begin
            if (exc_cnt_reg != 16'hffff) exc_cnt_reg <= exc_cnt_reg + 16'd1;
         end
      end
   end

   assign stat_int_cnt_o = int_cnt_reg;
   assign stat_exc_cnt_o = exc_cnt_reg;
`endif

endmodule

// File: tb/tb_except_ctrl.sv
// Randomized and directed bench for except_ctrl against a cycle-age reference model.
module tb_except_ctrl;

   localparam int F = 1;
   localparam int D = 2;
   localparam logic [31:0] VEC = 32'h0000_0020;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid_i, mem_stall_i, mem_in_delayslot_i;
   logic [31:0] mem_pc_i;
   logic        exc_syscall_i, exc_inst_invalid_i, exc_trap_i, exc_ovf_i, exc_eret_i;
   logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
   logic        wb_cp0_we_i;
   logic [4:0]  wb_cp0_waddr_i;
   logic [31:0] wb_cp0_wdata_i;
   logic [31:0] excepttype_o, except_pc_o, new_pc_o;
   logic        except_dslot_o, flush_o, busy_o;
`ifdef EXCEPT_STATS_EN
   logic [15:0] stat_int_cnt_o, stat_exc_cnt_o;
   int          m_int_cnt, m_exc_cnt;
`endif

   int          n_vec, n_err;
   int          age;
   logic [31:0] m_code, m_pc, m_target;
   logic        m_dslot;

   except_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(F), .DRAIN_CYCLES(D)) dut (
      .clk(clk), .rst(rst),
      .mem_valid_i(mem_valid_i), .mem_stall_i(mem_stall_i), .mem_pc_i(mem_pc_i),
      .mem_in_delayslot_i(mem_in_delayslot_i),
      .exc_syscall_i(exc_syscall_i), .exc_inst_invalid_i(exc_inst_invalid_i),
      .exc_trap_i(exc_trap_i), .exc_ovf_i(exc_ovf_i), .exc_eret_i(exc_eret_i),
      .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
      .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_wdata_i(wb_cp0_wdata_i),
`ifdef EXCEPT_STATS_EN
      .stat_int_cnt_o(stat_int_cnt_o), .stat_exc_cnt_o(stat_exc_cnt_o),
`endif
      .excepttype_o(excepttype_o), .except_pc_o(except_pc_o), .except_dslot_o(except_dslot_o),
      .flush_o(flush_o), .new_pc_o(new_pc_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: what CP0 state the instruction actually sees, then what event it raises.
   function automatic logic [31:0] ref_code();
      logic [31:0] st;
      logic [7:0]  ip;
      st = cp0_status_i;
      ip = cp0_cause_i[15:8];
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) st = wb_cp0_wdata_i;
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) ip[1:0] = wb_cp0_wdata_i[9:8];
      if ((ip & st[15:8]) != 8'h0 && st[0] && !st[1]) return 32'h01;
      if (exc_eret_i)         return 32'h0e;
      if (exc_syscall_i)      return 32'h08;
      if (exc_inst_invalid_i) return 32'h0a;
      if (exc_trap_i)         return 32'h0d;
      if (exc_ovf_i)          return 32'h0c;
      return 32'h0;
   endfunction

   function automatic logic [31:0] ref_epc();
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) return wb_cp0_wdata_i;
      return cp0_epc_i;
   endfunction

   task automatic clear_inputs();
      mem_valid_i = 0; mem_stall_i = 0; mem_pc_i = 0; mem_in_delayslot_i = 0;
      exc_syscall_i = 0; exc_inst_invalid_i = 0; exc_trap_i = 0; exc_ovf_i = 0; exc_eret_i = 0;
      cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
      wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_wdata_i = 0;
   endtask

   task automatic reset_model();
      age = 0; m_code = 0; m_pc = 0; m_target = 0; m_dslot = 0;
`ifdef EXCEPT_STATS_EN
      m_int_cnt = 0; m_exc_cnt = 0;
`endif
   endtask

   // Called just after a falling edge with inputs set; returns after the next falling edge.
   task automatic cycle();
      logic [31:0] c, t;
      logic        acc;
      logic        exp_flush;
      c   = ref_code();
      t   = (c == 32'h0e) ? ref_epc() : VEC;
      acc = (age == 0) && mem_valid_i && !mem_stall_i && (c != 0);
      @(posedge clk);
      if (acc) begin
         age = 1; m_code = c; m_pc = mem_pc_i; m_dslot = mem_in_delayslot_i; m_target = t;
`ifdef EXCEPT_STATS_EN
         if (c == 32'h01) begin
            if (m_int_cnt < 65535) m_int_cnt++;
         end else if (c != 32'h0e) begin
            if (m_exc_cnt < 65535) m_exc_cnt++;
         end
`endif
      end else if (age > 0) begin
         age = (age == F + D) ? 0 : age + 1;
      end
      #1;
      exp_flush = (age >= 1) && (age <= F);
      check_val("type",   excepttype_o, (age == 1) ? m_code : 32'h0);
      check_val("epc",    except_pc_o, m_pc);
      check_val("dslot",  {31'h0, except_dslot_o}, {31'h0, m_dslot});
      check_val("flush",  {31'h0, flush_o}, {31'h0, exp_flush});
      check_val("new_pc", new_pc_o, exp_flush ? m_target : 32'h0);
      check_val("busy",   {31'h0, busy_o}, {31'h0, (age != 0)});
`ifdef EXCEPT_STATS_EN
      check_val("stat_int", {16'h0, stat_int_cnt_o}, 32'(m_int_cnt));
      check_val("stat_exc", {16'h0, stat_exc_cnt_o}, 32'(m_exc_cnt));
`endif
      $display("cyc t=%0t age=%0d type=%h flush=%b new_pc=%h busy=%b", $time, age, excepttype_o, flush_o, new_pc_o, busy_o);
      @(negedge clk);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         clear_inputs();
         cycle();
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_type"},  excepttype_o, 32'h0);
      check_val({tag, "_epc"},   except_pc_o, 32'h0);
      check_val({tag, "_dslot"}, {31'h0, except_dslot_o}, 32'h0);
      check_val({tag, "_flush"}, {31'h0, flush_o}, 32'h0);
      check_val({tag, "_newpc"}, new_pc_o, 32'h0);
      check_val({tag, "_busy"},  {31'h0, busy_o}, 32'h0);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      clear_inputs();
      reset_model();
      rst = 1;
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst = 0;

      // Syscall at 0x100: code 08, flush one cycle, busy for three.
      clear_inputs();
      mem_valid_i = 1; mem_pc_i = 32'h100; exc_syscall_i = 1;
      cycle();
      check_val("sys_type", excepttype_o, 32'h08);
      check_val("sys_pc", except_pc_o, 32'h100);
      check_val("sys_newpc", new_pc_o, 32'h20);
      idle_cycles(4);

      // Eret with EPC bypassed from WB.
      clear_inputs();
      mem_valid_i = 1; mem_pc_i = 32'h140; exc_eret_i = 1; cp0_epc_i = 32'h200;
      wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_wdata_i = 32'h300;
      cycle();
      check_val("eret_type", excepttype_o, 32'h0e);
      check_val("eret_newpc", new_pc_o, 32'h300);
      idle_cycles(4);

      // Pending interrupt held off by a 3-cycle stall.
      for (int i = 0; i < 4; i++) begin
         clear_inputs();
         mem_valid_i = 1; mem_pc_i = 32'h180; cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
         mem_stall_i = (i < 3);
         cycle();
         if (i < 3) check_val("int_stalled", excepttype_o, 32'h0);
      end
      check_val("int_type", excepttype_o, 32'h01);
      idle_cycles(4);

      // EXL masks the interrupt; overflow goes through instead.
      clear_inputs();
      mem_valid_i = 1; mem_pc_i = 32'h1c0; cp0_status_i = 32'h0000_0403; cp0_cause_i = 32'h0000_0400;
      exc_ovf_i = 1;
      cycle();
      check_val("exl_ovf", excepttype_o, 32'h0c);
      idle_cycles(4);

      // Overflow+syscall together, then syscall during drain is ignored.
      clear_inputs();
      mem_valid_i = 1; mem_pc_i = 32'h200; exc_ovf_i = 1; exc_syscall_i = 1;
      cycle();
      check_val("prio_type", excepttype_o, 32'h08);
      clear_inputs();
      cycle();
      clear_inputs();
      mem_valid_i = 1; mem_pc_i = 32'h204; exc_syscall_i = 1;
      cycle();
      check_val("drain_ignored", excepttype_o, 32'h0);
      check_val("drain_pc", except_pc_o, 32'h200);
      idle_cycles(4);

      // Async reset while flushing.
      clear_inputs();
      mem_valid_i = 1; mem_pc_i = 32'h240; mem_in_delayslot_i = 1; exc_trap_i = 1;
      cycle();
      check_val("pre_rst_flush", {31'h0, flush_o}, 32'h1);
      clear_inputs();
      #2 rst = 1;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      rst = 0;
      reset_model();
      idle_cycles(2);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         clear_inputs();
         mem_valid_i        = ($urandom_range(0, 3) != 0);
         mem_stall_i        = ($urandom_range(0, 4) == 0);
         mem_pc_i           = $urandom & 32'hffff_fffc;
         mem_in_delayslot_i = $urandom_range(0, 1);
         exc_syscall_i      = ($urandom_range(0, 9) == 0);
         exc_inst_invalid_i = ($urandom_range(0, 9) == 0);
         exc_trap_i         = ($urandom_range(0, 9) == 0);
         exc_ovf_i          = ($urandom_range(0, 9) == 0);
         exc_eret_i         = ($urandom_range(0, 11) == 0);
         cp0_status_i       = {16'h0, 8'($urandom), 6'h0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7)};
         cp0_cause_i        = ($urandom_range(0, 9) < 3) ? ($urandom & 32'h00c0_ff00) : 32'h0;
         cp0_epc_i          = $urandom;
         wb_cp0_we_i        = ($urandom_range(0, 9) < 3);
         case ($urandom_range(0, 3))
            0: wb_cp0_waddr_i = 5'd12;
            1: wb_cp0_waddr_i = 5'd13;
            2: wb_cp0_waddr_i = 5'd14;
            default: wb_cp0_waddr_i = 5'd5;
         endcase
         wb_cp0_wdata_i = $urandom;
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
